// File: rtl/debug_loader.sv
// debug_loader: UART command FSM that loads, runs/steps and dumps the pipeline's state.
// Define DEBUG_STEP_EN to compile in the single-step 'S' command.
module debug_loader #(
  parameter int DATA_SZ = 8,
  parameter int INST_SZ = 32,
  parameter int REG_SZ  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [DATA_SZ-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_busy,
  output logic [DATA_SZ-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_write,
  output logic [INST_SZ-1:0] o_instruction,
  output logic               o_enable,
  output logic [REG_SZ-1:0]  o_debug_addr,
  input  logic [INST_SZ-1:0] i_pc,
  input  logic [INST_SZ-1:0] i_reg,
  input  logic [INST_SZ-1:0] i_mem,
  input  logic               i_halt
);

  localparam int SH_W   = INST_SZ - DATA_SZ;
  localparam int WIDX_W = REG_SZ + 2;
  localparam int NREG   = 1 << REG_SZ;
  localparam logic [WIDX_W-1:0]  LAST_WORD = WIDX_W'(2 * NREG);
  localparam logic [DATA_SZ-1:0] CMD_LOAD  = DATA_SZ'('h4C);
  localparam logic [DATA_SZ-1:0] CMD_RUN   = DATA_SZ'('h52);
  localparam logic [DATA_SZ-1:0] CMD_DUMP  = DATA_SZ'('h44);
  localparam logic [INST_SZ-1:0] HALT_WORD = INST_SZ'('h3F);
`ifdef DEBUG_STEP_EN
  localparam logic [DATA_SZ-1:0] CMD_STEP  = DATA_SZ'('h53);
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_RUN, ST_DSET, ST_DSEND, ST_DWAIT
`ifdef DEBUG_STEP_EN
    , ST_STEP
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [SH_W-1:0]     shift_q, shift_d;
  logic [INST_SZ-1:0]  instr_q, instr_d;
  logic                write_q, write_d;
  logic                enable_q, enable_d;
  logic [DATA_SZ-1:0]  tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic [REG_SZ-1:0]   addr_q, addr_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [1:0]          bidx_q, bidx_d;
  logic [INST_SZ-1:0]  word_q, word_d;
  logic                phase_q, phase_d;
  logic [INST_SZ-1:0]  new_word;

  assign new_word = {shift_q, i_rx_data};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      instr_q    <= '0;
      write_q    <= 1'b0;
      enable_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      addr_q     <= '0;
      widx_q     <= '0;
      bidx_q     <= '0;
      word_q     <= '0;
      phase_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      instr_q    <= instr_d;
      write_q    <= write_d;
      enable_q   <= enable_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      addr_q     <= addr_d;
      widx_q     <= widx_d;
      bidx_q     <= bidx_d;
      word_q     <= word_d;
      phase_q    <= phase_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    instr_d    = instr_q;
    write_d    = 1'b0;
    enable_d   = 1'b0;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    addr_d     = addr_q;
    widx_d     = widx_q;
    bidx_d     = bidx_q;
    word_d     = word_q;
    phase_d    = phase_q;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_LOAD) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end else if (i_rx_data == CMD_RUN && !i_halt) begin
            state_d  = ST_RUN;
            enable_d = 1'b1;
          end else if (i_rx_data == CMD_DUMP) begin
            state_d = ST_DSET;
            widx_d  = '0;
            bidx_d  = '0;
            phase_d = 1'b0;
          end
`ifdef DEBUG_STEP_EN
          else if (i_rx_data == CMD_STEP) begin
            state_d  = ST_STEP;
            enable_d = 1'b1;
          end
`endif
        end
      end

      ST_LOAD: begin
        if (i_rx_done) begin
          shift_d = new_word[SH_W-1:0];
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            instr_d = new_word;
            write_d = 1'b1;
            if (new_word == HALT_WORD) state_d = ST_IDLE;
          end
        end
      end

      ST_RUN: begin
        // Halt sampled this edge drops enable on the very next cycle.
        if (i_halt) begin
          state_d = ST_DSET;
          widx_d  = '0;
          bidx_d  = '0;
          phase_d = 1'b0;
        end else begin
          enable_d = 1'b1;
        end
      end

`ifdef DEBUG_STEP_EN
      ST_STEP: begin
        state_d = ST_DSET;
        widx_d  = '0;
        bidx_d  = '0;
        phase_d = 1'b0;
      end
`endif

      ST_DSET: begin
        // Word 0 is the PC; words 1..NREG are regs, the rest memory.
        if (!phase_q) begin
          addr_d  = (widx_q == '0) ? '0 : REG_SZ'(widx_q - WIDX_W'(1));
          phase_d = 1'b1;
        end else begin
          state_d = ST_DSEND;
          phase_d = 1'b0;
        end
      end

      ST_DSEND: begin
        if (!phase_q) begin
          if (widx_q == '0)                    word_d = i_pc;
          else if (widx_q <= WIDX_W'(NREG))    word_d = i_reg;
          else                                 word_d = i_mem;
          phase_d = 1'b1;
        end else if (!i_tx_busy) begin
          tx_data_d  = word_q[INST_SZ-1 -: DATA_SZ];
          tx_start_d = 1'b1;
          word_d     = word_q << DATA_SZ;
          state_d    = ST_DWAIT;
          phase_d    = 1'b0;
        end
      end

      ST_DWAIT: begin
        // The transmitter raises busy one cycle after the start pulse.
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (!i_tx_busy) begin
          if (bidx_q == 2'd3) begin
            bidx_d  = '0;
            phase_d = 1'b0;
            if (widx_q == LAST_WORD) begin
              addr_d  = '0;
              widx_d  = '0;
              state_d = ST_IDLE;
            end else begin
              widx_d  = widx_q + WIDX_W'(1);
              state_d = ST_DSET;
            end
          end else begin
            bidx_d  = bidx_q + 2'd1;
            phase_d = 1'b1;
            state_d = ST_DSEND;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign o_tx_data     = tx_data_q;
  assign o_tx_start    = tx_start_q;
  assign o_write       = write_q;
  assign o_instruction = instr_q;
  assign o_enable      = enable_q;
  assign o_debug_addr  = addr_q;

endmodule

// File: tb/tb_debug_loader.sv
// Scoreboard bench for debug_loader: models UART tx, pipeline halt and debug read data.
module tb_debug_loader;
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_done = 1'b0;
  logic        i_tx_busy = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        o_write;
  logic [31:0] o_instruction;
  logic        o_enable;
  logic [4:0]  o_debug_addr;
  logic [31:0] i_pc, i_reg, i_mem;
  logic        i_halt = 1'b0;

  localparam logic [31:0] PC_VAL = 32'h0040_0120;

  function automatic logic [31:0] reg_model(input logic [4:0] a);
    return {8'h11, 3'b000, a, 8'hC3, ~{3'b000, a}};
  endfunction
  function automatic logic [31:0] mem_model(input logic [4:0] a);
    return {8'h8E, 3'b000, a, 3'b000, a, 8'h5A};
  endfunction

  assign i_pc  = PC_VAL;
  assign i_reg = reg_model(o_debug_addr);
  assign i_mem = mem_model(o_debug_addr);

  debug_loader dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .i_tx_busy(i_tx_busy),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_write(o_write), .o_instruction(o_instruction), .o_enable(o_enable),
    .o_debug_addr(o_debug_addr),
    .i_pc(i_pc), .i_reg(i_reg), .i_mem(i_mem), .i_halt(i_halt)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0, n_bad = 0;
  logic [7:0]  exp_tx_q[$];
  logic [31:0] exp_wr_q[$];
  int tx_cnt = 0, wr_cnt = 0, en_cnt = 0;
  int extra_tx = 0, extra_wr = 0, busy_viol = 0;
  int busy_len = 1, busy_left = 0;
  bit halt_auto = 1'b0;
  int halt_after = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transmitter and pipeline model, sampled on the falling edge.
  initial forever begin
    @(negedge i_clk);
    if (o_enable) begin
      en_cnt++;
      if (halt_auto && en_cnt == halt_after) i_halt = 1'b1;
    end
    if (o_write) begin
      wr_cnt++;
      if (exp_wr_q.size() == 0) extra_wr++;
      else check("wr_word", o_instruction, exp_wr_q.pop_front());
    end
    if (o_tx_start) begin
      if (i_tx_busy) busy_viol++;
      tx_cnt++;
      if (exp_tx_q.size() == 0) extra_tx++;
      else check($sformatf("tx_byte%0d", tx_cnt), {24'h0, o_tx_data}, {24'h0, exp_tx_q.pop_front()});
      i_tx_busy = 1'b1;
      busy_left = busy_len;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) i_tx_busy = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk); #1;
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge i_clk); #1;
    i_rx_done = 1'b0;
    repeat (2) @(posedge i_clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit expect_write);
    if (expect_write) exp_wr_q.push_back(w);
    for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
  endtask

  task automatic push_dump();
    for (int w = 0; w < 65; w++) begin
      logic [31:0] v;
      if (w == 0)       v = PC_VAL;
      else if (w <= 32) v = reg_model(5'(w - 1));
      else              v = mem_model(5'(w - 33));
      for (int b = 3; b >= 0; b--) exp_tx_q.push_back(v[8*b +: 8]);
    end
  endtask

  task automatic wait_tx(input string tag, input int target);
    for (int i = 0; i < 30000 && tx_cnt < target; i++) @(negedge i_clk);
    check(tag, tx_cnt, target);
    repeat (busy_len + 10) @(negedge i_clk);
    check({tag, "_q_empty"}, exp_tx_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tx_data"}, {24'h0, o_tx_data}, 32'h0);
    check({tag, "_tx_start"}, {31'h0, o_tx_start}, 32'h0);
    check({tag, "_write"}, {31'h0, o_write}, 32'h0);
    check({tag, "_instr"}, o_instruction, 32'h0);
    check({tag, "_enable"}, {31'h0, o_enable}, 32'h0);
    check({tag, "_addr"}, {27'h0, o_debug_addr}, 32'h0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge i_clk); #2;
    i_reset = 1'b0;
    #1;
    check_zero(tag);
    exp_tx_q.delete();
    busy_left = 0;
    i_tx_busy = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b1;
  endtask

  initial begin
    int base, wbase;
    #1;
    check_zero("rst");
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;

    // Program load; HALT word returns to IDLE.
    send_byte(8'h4C);
    send_word(32'h2002_0002, 1'b1);
    send_word(32'h0002_5021, 1'b1);
    send_word(32'h0000_003F, 1'b1);
    check("load_writes", wr_cnt, 3);
    send_word(32'h0000_003F, 1'b0);
    repeat (5) @(negedge i_clk);
    check("idle_after_halt", wr_cnt, 3);
    send_byte(8'h4C);
    send_word(32'h1234_5678, 1'b1);
    send_word(32'h0000_003F, 1'b1);
    check("reload_writes", wr_cnt, 5);
    check("reload_q_empty", exp_wr_q.size(), 0);

    // Run until halt after 6 enable cycles, then full dump.
    en_cnt = 0; halt_after = 6; halt_auto = 1'b1;
    base = tx_cnt;
    push_dump();
    send_byte(8'h52);
    wait_tx("run_dump", base + 260);
    check("run_enable_cycles", en_cnt, 6);
    check("addr_after_dump", {27'h0, o_debug_addr}, 32'h0);

    // Ignored input: 'R' while halted, unknown byte.
    base = tx_cnt; wbase = wr_cnt; en_cnt = 0;
    send_byte(8'h52);
    send_byte(8'h7A);
    repeat (50) @(negedge i_clk);
    check("ign_enable", en_cnt, 0);
    check("ign_tx", tx_cnt, base);
    check("ign_write", wr_cnt, wbase);

    // Slow transmitter: 50 busy cycles per byte.
    i_halt = 1'b0; en_cnt = 0; halt_after = 3; busy_len = 50;
    base = tx_cnt;
    push_dump();
    send_byte(8'h52);
    wait_tx("slow_dump", base + 260);
    check("slow_enable_cycles", en_cnt, 3);
    busy_len = 1;

    // Single step.
    i_halt = 1'b0; halt_auto = 1'b0; en_cnt = 0;
    base = tx_cnt;
`ifdef DEBUG_STEP_EN
    push_dump();
    send_byte(8'h53);
    wait_tx("step_dump", base + 260);
    check("step_enable_cycles", en_cnt, 1);
`else
    send_byte(8'h53);
    repeat (100) @(negedge i_clk);
    check("nostep_enable", en_cnt, 0);
    check("nostep_tx", tx_cnt, base);
`endif

    // Reset mid-load discards the partial word.
    send_byte(8'h4C);
    send_byte(8'h11);
    send_byte(8'h22);
    do_reset("rst_load");
    send_byte(8'h4C);
    send_word(32'hAABB_CCDD, 1'b1);
    send_word(32'h0000_003F, 1'b1);
    check("post_rst_q_empty", exp_wr_q.size(), 0);

    // Reset during the 100th dump byte aborts transmission.
    i_halt = 1'b0; halt_auto = 1'b1; en_cnt = 0; halt_after = 2;
    base = tx_cnt;
    push_dump();
    send_byte(8'h52);
    for (int i = 0; i < 5000 && tx_cnt < base + 100; i++) @(negedge i_clk);
    check("pre_abort_bytes", tx_cnt, base + 100);
    do_reset("rst_dump");
    base = tx_cnt;
    repeat (200) @(negedge i_clk);
    check("abort_no_tx", tx_cnt, base);
    i_halt = 1'b0; halt_auto = 1'b0;
    wbase = wr_cnt;
    send_byte(8'h4C);
    send_word(32'hDEAD_BEEF, 1'b1);
    send_word(32'h0000_003F, 1'b1);
    check("post_abort_writes", wr_cnt, wbase + 2);
    check("post_abort_q_empty", exp_wr_q.size(), 0);

    check("busy_violations", busy_viol, 0);
    check("extra_tx", extra_tx, 0);
    check("extra_wr", extra_wr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
